// File: rtl/rr_dec_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_dec_arbiter_pkg
// Shared definitions for the round-robin arbiter slice: requester count,
// index/counter widths and the two-state FSM encoding.
// -----------------------------------------------------------------------------
package rr_dec_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_dec_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_dec_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   req     : per-requester request vector
//   done    : release strobe from the current holder
//   gnt     : one-hot grant (zero when no grant active)
//   gnt_idx : binary index of current/last holder
//   gnt_vld : grant active
//   timeout : one-cycle pulse when the hold limit revoked a grant
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_dec_arbiter_if;
  import rr_dec_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_vld, timeout
  );

endinterface

// File: rtl/rr_dec_arbiter_grant_dec3to8.sv
// -----------------------------------------------------------------------------
// grant_dec3to8
// Purely combinational 3-to-8 decoder with enable.
//   idx    : binary index
//   en     : decoder enable; output is all zero when low
//   onehot : one-hot decode of idx
// -----------------------------------------------------------------------------
module grant_dec3to8
  import rr_dec_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  onehot
);

  // one-hot decode of idx, gated by en
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      case (idx)
        3'd0:    onehot = 8'h01;
        3'd1:    onehot = 8'h02;
        3'd2:    onehot = 8'h04;
        3'd3:    onehot = 8'h08;
        3'd4:    onehot = 8'h10;
        3'd5:    onehot = 8'h20;
        3'd6:    onehot = 8'h40;
        3'd7:    onehot = 8'h80;
        default: onehot = 8'h00;
      endcase
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// -----------------------------------------------------------------------------
// rr_dec_arbiter
// Eight-way round-robin arbiter with a per-grant hold limit.
//   clk      : system clock, all state on rising edge
//   rst      : synchronous active-high reset
//   bus      : slave side of rr_dec_arbiter_if (req/done in, gnt/gnt_idx/
//              gnt_vld/timeout out)
// Parameter MAX_HOLD (1..255): maximum consecutive grant cycles per holder.
// Every grant is followed by at least one IDLE cycle; only gnt is
// combinational (decoded from the registered index and valid).
// -----------------------------------------------------------------------------
module rr_dec_arbiter
  import rr_dec_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst,
  rr_dec_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] idx_r;
  logic             vld_r;
  logic             timeout_r;
  logic [CNT_W-1:0] cnt_r;

  logic [IDX_W-1:0] winner_s;
  logic             holder_req_s;
  logic             hold_hit_s;
  logic             release_s;
  logic [NREQ-1:0]  gnt_s;

  // First requester found scanning p, p+1, ... p+7 (mod 8). The scan runs
  // backwards so the last assignment made is the nearest one to p.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] cand;
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = p + IDX_W'(k);
      if (r[cand]) begin
        rr_pick = cand;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // winner selection and release decode
  always_comb begin
    winner_s     = rr_pick(bus.req, ptr_r);
    holder_req_s = bus.req[idx_r];
    hold_hit_s   = (cnt_r == HOLD_LAST);
    release_s    = bus.done | ~holder_req_s | hold_hit_s;
  end

  // arbitration FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 3'd0;
      idx_r     <= 3'd0;
      vld_r     <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req != 8'h00) begin
            idx_r   <= winner_s;
            vld_r   <= 1'b1;
            cnt_r   <= 8'd0;
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            state_r   <= ST_IDLE;
            vld_r     <= 1'b0;
            ptr_r     <= idx_r + 3'd1;
            // pulse only when the hold limit alone ended the grant
            timeout_r <= hold_hit_s & ~bus.done & holder_req_s;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          vld_r   <= 1'b0;
        end
      endcase
    end
  end

  grant_dec3to8 u_dec (
    .idx    (idx_r),
    .en     (vld_r),
    .onehot (gnt_s)
  );

  assign bus.gnt     = gnt_s;
  assign bus.gnt_idx = idx_r;
  assign bus.gnt_vld = vld_r;
  assign bus.timeout = timeout_r;

endmodule
